booth_pp_accum: RTL and testbench

- Consumer of the Booth multiplier's split partial-product stream: Sum_result carries the low 16-bit product half; Carry_result is misaligned as {H_k[15:0], H_(k-1)[31:16]}.
- For a multi-word operand A times a 16-bit word b, streamed one 32-bit chunk per cycle, it reconstructs column words of T + A*b: it adds sum, carry and an accumulator word, propagates inter-column carry and emits one extra flush column.
- Sits between the multiplier top and the Montgomery datapath's T register.

---
 rtl/booth_pp_accum.sv | 118 +++++++++++
 tb/tb_booth_pp_accum.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_accum.sv
// Rebuilds the column words of T + A*b from the Booth multiplier's split sum/carry stream.
// Each column adds sum, carry and accumulator words plus a carry. One extra flush column closes the operand.
module booth_pp_accum #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned MAXW  = 64,
    parameter int unsigned IDXW  = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pp_valid,
    input  logic             pp_first,
    input  logic             pp_last,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] carry_in,
    input  logic [WIDTH-1:0] acc_in,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_word,
    output logic [IDXW-1:0]  res_idx,
    output logic             res_last,
    output logic             res_cout,
    output logic             busy,
    output logic             err
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned CW   = WIDTH + 2;
    localparam int unsigned FW   = WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    state_t           state;
    logic [1:0]       creg;
    logic [IDXW-1:0]  cnt;
    logic [WIDTH-1:0] cmask;
    logic [1:0]       creg_eff;
    logic [CW-1:0]    col;
    logic [FW-1:0]    fw;
    logic             at_limit;

    // First beat has no H_(k-1) below it and starts with a clean carry.
    always_comb begin
        cmask    = carry_in;
        creg_eff = creg;
        if (state == IDLE) begin
            cmask[HALF-1:0] = '0;
            creg_eff        = 2'd0;
        end
        col      = CW'(sum_in) + CW'(cmask) + CW'(acc_in) + CW'(creg_eff);
        fw       = FW'(carry_in[HALF-1:0]) + FW'(acc_in) + FW'(creg);
        at_limit = (cnt == IDXW'(MAXW - 1));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            creg      <= 2'd0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_word  <= '0;
            res_idx   <= '0;
            res_last  <= 1'b0;
            res_cout  <= 1'b0;
            err       <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_cout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pp_valid) begin
                        if (pp_first) begin
                            err       <= 1'b0;
                            res_valid <= 1'b1;
                            res_word  <= col[WIDTH-1:0];
                            res_idx   <= '0;
                            creg      <= col[CW-1:WIDTH];
                            cnt       <= IDXW'(1);
                            state     <= pp_last ? FLUSH : ACCUM;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    // Carry alignment needs contiguous beats; any break abandons the operand.
                    if (!pp_valid || pp_first || (at_limit && !pp_last)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        res_valid <= 1'b1;
                        res_word  <= col[WIDTH-1:0];
                        res_idx   <= cnt;
                        creg      <= col[CW-1:WIDTH];
                        cnt       <= cnt + IDXW'(1);
                        if (pp_last) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    res_valid <= 1'b1;
                    res_word  <= fw[WIDTH-1:0];
                    res_cout  <= fw[WIDTH];
                    res_last  <= 1'b1;
                    res_idx   <= cnt;
                    state     <= IDLE;
                    if (pp_valid) begin
                        err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_pp_accum.sv
// Self-checking bench for booth_pp_accum: directed vector table, MAXW and reset sequences, randomized operands.
module tb_booth_pp_accum;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pp_valid, pp_first, pp_last;
    logic [31:0] sum_in, carry_in, acc_in;

    logic        res_valid_a, res_last_a, res_cout_a, busy_a, err_a;
    logic [31:0] res_word_a;
    logic [6:0]  res_idx_a;
    logic        res_valid_b, res_last_b, res_cout_b, busy_b, err_b;
    logic [31:0] res_word_b;
    logic [6:0]  res_idx_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_pp_accum u_dut_a (
        .clk(clk), .rstn(rstn), .pp_valid(pp_valid), .pp_first(pp_first), .pp_last(pp_last),
        .sum_in(sum_in), .carry_in(carry_in), .acc_in(acc_in),
        .res_valid(res_valid_a), .res_word(res_word_a), .res_idx(res_idx_a),
        .res_last(res_last_a), .res_cout(res_cout_a), .busy(busy_a), .err(err_a)
    );

    booth_pp_accum #(.MAXW(4)) u_dut_b (
        .clk(clk), .rstn(rstn), .pp_valid(pp_valid), .pp_first(pp_first), .pp_last(pp_last),
        .sum_in(sum_in), .carry_in(carry_in), .acc_in(acc_in),
        .res_valid(res_valid_b), .res_word(res_word_b), .res_idx(res_idx_b),
        .res_last(res_last_b), .res_cout(res_cout_b), .busy(busy_b), .err(err_b)
    );

    // Captured emitted words of instance a: {last, cout, idx, word}.
    logic [40:0] mq[$];
    always @(negedge clk) begin
        if (res_valid_a) mq.push_back({res_last_a, res_cout_a, res_idx_a, res_word_a});
    end

    typedef struct {
        logic        v, f, l;
        logic [31:0] s, c, a;
        logic        ev;
        logic [31:0] ew;
        logic [6:0]  ei;
        logic        el, ec, ee, eb;
    } vec_t;

    vec_t tv[17];

    function automatic vec_t mk(input logic v, input logic f, input logic l,
                                input logic [31:0] s, input logic [31:0] c, input logic [31:0] a,
                                input logic ev, input logic [31:0] ew, input logic [6:0] ei,
                                input logic el, input logic ec, input logic ee, input logic eb);
        vec_t r;
        r.v = v; r.f = f; r.l = l; r.s = s; r.c = c; r.a = a;
        r.ev = ev; r.ew = ew; r.ei = ei; r.el = el; r.ec = ec; r.ee = ee; r.eb = eb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic l,
                         input logic [31:0] s, input logic [31:0] c, input logic [31:0] a);
        pp_valid = v; pp_first = f; pp_last = l;
        sum_in = s; carry_in = c; acc_in = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the emitted words are the base-2^32 digits of one wide sum of every column term.
    task automatic run_rand(input int n);
        logic [31:0]  s[9], c[9], a[9];
        logic [31:0]  cm;
        logic [319:0] x;
        logic [40:0]  exp;
        int           got;
        mq.delete();
        x = '0;
        for (int k = 0; k <= n; k++) begin
            s[k] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            c[k] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            a[k] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
        for (int k = 0; k < n; k++) begin
            cm = c[k];
            if (k == 0) cm[15:0] = 16'h0;
            x = x + (320'(s[k]) << (32 * k));
            x = x + (320'(cm) << (32 * k));
            x = x + (320'(a[k]) << (32 * k));
        end
        x = x + ((320'(c[n][15:0]) + 320'(a[n])) << (32 * n));
        for (int k = 0; k < n; k++) begin
            drive(1'b1, k == 0, k == n - 1, s[k], c[k], a[k]);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, $urandom, c[n], a[n]);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        got = mq.size();
        chk($sformatf("rand_n%0d_count", n), 64'(got), 64'(n + 1));
        for (int i = 0; i <= n && i < got; i++) begin
            exp = {i == n, (i == n) ? x[32 * (n + 1)] : 1'b0, 7'(i), x[32 * i +: 32]};
            chk($sformatf("rand_n%0d_word%0d", n, i), 64'(mq[i]), 64'(exp));
        end
        chk($sformatf("rand_n%0d_err", n), 64'({err_a, busy_a}), 64'(0));
    endtask

    initial begin
        rstn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        tv[0]  = mk(1, 1, 0, 32'hFFFF_FFFF, 32'h0001_1234, 32'h0,         1, 32'h0000_FFFF, 7'd0, 0, 0, 0, 1);
        tv[1]  = mk(1, 0, 1, 32'h0,         32'h0000_0005, 32'h0,         1, 32'h0000_0006, 7'd1, 0, 0, 0, 1);
        tv[2]  = mk(0, 0, 0, 32'h0,         32'h1234_00AB, 32'h0,         1, 32'h0000_00AB, 7'd2, 1, 0, 0, 0);
        tv[3]  = mk(1, 1, 0, 32'h0,         32'h0,         32'h0,         1, 32'h0,         7'd0, 0, 0, 0, 1);
        tv[4]  = mk(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFD, 7'd1, 0, 0, 0, 1);
        tv[5]  = mk(0, 0, 0, 32'h0,         32'h0,         32'h0,         1, 32'h0000_0002, 7'd2, 1, 0, 0, 0);
        tv[6]  = mk(1, 1, 0, 32'h0,         32'h0,         32'h0,         1, 32'h0,         7'd0, 0, 0, 0, 1);
        tv[7]  = mk(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFD, 7'd1, 0, 0, 0, 1);
        tv[8]  = mk(0, 0, 0, 32'h0,         32'h0000_FFFF, 32'hFFFF_FFFF, 1, 32'h0001_0000, 7'd2, 1, 1, 0, 0);
        tv[9]  = mk(1, 1, 0, 32'h1,         32'h0,         32'h0,         1, 32'h0000_0001, 7'd0, 0, 0, 0, 1);
        tv[10] = mk(0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 32'h0,         7'd0, 0, 0, 1, 0);
        tv[11] = mk(1, 0, 0, 32'h7,         32'h0,         32'h0,         0, 32'h0,         7'd0, 0, 0, 1, 0);
        tv[12] = mk(1, 1, 1, 32'h2,         32'h0,         32'h0,         1, 32'h0000_0002, 7'd0, 0, 0, 0, 1);
        tv[13] = mk(0, 0, 0, 32'h0,         32'h0,         32'h3,         1, 32'h0000_0003, 7'd1, 1, 0, 0, 0);
        tv[14] = mk(1, 1, 1, 32'h0,         32'h0,         32'h0,         1, 32'h0,         7'd0, 0, 0, 0, 1);
        tv[15] = mk(1, 0, 0, 32'h0,         32'h0,         32'h0,         1, 32'h0,         7'd1, 1, 0, 1, 0);
        tv[16] = mk(0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 32'h0,         7'd0, 0, 0, 1, 0);

        step();
        step();
        chk("reset_a", 64'({res_valid_a, res_word_a, res_idx_a, res_last_a, res_cout_a, busy_a, err_a}), 64'(0));
        chk("reset_b", 64'({res_valid_b, res_word_b, res_idx_b, res_last_b, res_cout_b, busy_b, err_b}), 64'(0));
        rstn = 1'b1;
        step();

        for (int i = 0; i < 17; i++) begin
            drive(tv[i].v, tv[i].f, tv[i].l, tv[i].s, tv[i].c, tv[i].a);
            step();
            chk($sformatf("vec%0d_ctrl", i), 64'({res_valid_a, res_last_a, res_cout_a, err_a, busy_a}),
                64'({tv[i].ev, tv[i].el, tv[i].ec, tv[i].ee, tv[i].eb}));
            if (tv[i].ev)
                chk($sformatf("vec%0d_word", i), 64'({res_idx_a, res_word_a}), 64'({tv[i].ei, tv[i].ew}));
        end

        // Operand length limit on the MAXW=4 instance.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k == 0, 1'b0, 32'(k + 1), 32'h0, 32'h0);
            step();
            if (k < 3)
                chk($sformatf("maxw_beat%0d", k), 64'({res_valid_b, res_idx_b, res_word_b, err_b, busy_b}),
                    64'({1'b1, 7'(k), 32'(k + 1), 1'b0, 1'b1}));
            else
                chk("maxw_drop", 64'({res_valid_b, res_last_b, err_b, busy_b}), 64'({1'b0, 1'b0, 1'b1, 1'b0}));
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk("maxw_after", 64'({res_valid_b, res_last_b, err_b, busy_b}), 64'({1'b0, 1'b0, 1'b1, 1'b0}));
        step();

        // Asynchronous reset in the middle of an operand.
        drive(1'b1, 1'b1, 1'b0, 32'h5, 32'h0, 32'h0);
        step();
        chk("pre_reset", 64'({res_valid_a, res_word_a, busy_a}), 64'({1'b1, 32'h5, 1'b1}));
        drive(1'b1, 1'b0, 1'b0, 32'h9, 32'h0, 32'h0);
        #2 rstn = 1'b0;
        #1;
        chk("async_reset", 64'({res_valid_a, res_word_a, res_idx_a, res_last_a, res_cout_a, busy_a, err_a}), 64'(0));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        rstn = 1'b1;
        step();

        for (int t = 0; t < 30; t++) run_rand($urandom_range(1, 8));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
